// File: rtl/tone_generator_if.sv
// Tone generator port bundle: timebase tick, key and octave in; square wave
// and note status out. The controller side drives the inputs (master); the
// generator consumes them (slave).
interface tone_generator_if;
  logic       tick;
  logic [7:0] key;
  logic [1:0] octave;
  logic       audio;
  logic       note_active;
  logic [2:0] note_idx;

  modport master (
    output tick,
    output key,
    output octave,
    input  audio,
    input  note_active,
    input  note_idx
  );

  modport slave (
    input  tick,
    input  key,
    input  octave,
    output audio,
    output note_active,
    output note_idx
  );
endinterface

// File: rtl/tone_generator.sv
// Square-wave tone generator. Counts rising edges of the divided timebase
// tick and toggles audio every 'half' events. Note, octave and release
// decisions are taken only at full-period boundaries (the low-to-high toggle),
// so the waveform never carries a runt pulse.
//
// state | meaning
// IDLE  | no note; audio low, waiting for any key bit
// PLAY  | note sounding; cnt counts tick events within the current half-period
module tone_generator #(
  parameter int W = 14
) (
  input logic          clk,
  input logic          rst,
  tone_generator_if.slave bus
);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t         state;
  logic           tick_d;
  logic [W-1:0]   cnt;
  logic [W-1:0]   half;
  logic           audio_q;
  logic           active_q;
  logic [2:0]     idx_q;

  logic           tick_ev;
  logic           key_any;
  logic [2:0]     enc_idx;
  logic [W-1:0]   next_half;
  logic [W-1:0]   half_m1;

  // Base half-periods in tick events, C4..C5.
  function automatic logic [W-1:0] base_half(input logic [2:0] idx);
    logic [W-1:0] h;
    case (idx)
      3'd0:    h = W'(5972);
      3'd1:    h = W'(5321);
      3'd2:    h = W'(4740);
      3'd3:    h = W'(4474);
      3'd4:    h = W'(3986);
      3'd5:    h = W'(3551);
      3'd6:    h = W'(3164);
      default: h = W'(2986);
    endcase
    return h;
  endfunction

  // Lowest set key bit wins.
  function automatic logic [2:0] lowest_idx(input logic [7:0] k);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (k[i]) r = 3'(i);
    end
    return r;
  endfunction

  assign tick_ev   = bus.tick & ~tick_d;
  assign key_any   = |bus.key;
  assign enc_idx   = lowest_idx(bus.key);
  // Octave is folded into half at load time, so half alone carries the
  // latched octave for the rest of the period.
  assign next_half = base_half(enc_idx) >> bus.octave;
  assign half_m1   = half - W'(1);

  assign bus.audio       = audio_q;
  assign bus.note_active = active_q;
  assign bus.note_idx    = idx_q;

  // Tick edge detect, half-period counter and note sequencing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      tick_d   <= 1'b0;
      cnt      <= '0;
      half     <= '0;
      audio_q  <= 1'b0;
      active_q <= 1'b0;
      idx_q    <= 3'd0;
    end else begin
      tick_d <= bus.tick;
      case (state)
        IDLE: begin
          audio_q <= 1'b0;
          cnt     <= '0;
          if (key_any) begin
            idx_q    <= enc_idx;
            half     <= next_half;
            audio_q  <= 1'b1;
            active_q <= 1'b1;
            state    <= PLAY;
          end
        end
        PLAY: begin
          if (tick_ev) begin
            if (cnt != half_m1) begin
              cnt <= cnt + W'(1);
            end else begin
              cnt <= '0;
              if (audio_q) begin
                audio_q <= 1'b0;
              end else if (key_any) begin
                // Full period done: pick up whatever key/octave is present now.
                idx_q   <= enc_idx;
                half    <= next_half;
                audio_q <= 1'b1;
              end else begin
                active_q <= 1'b0;
                state    <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tone_generator.sv
// Bench for tone_generator. Stimulus pushes the expected sequence of output
// edges (level, note status, tick events since the previous edge) into a
// queue; a monitor pops one entry per observed output change and compares.
module tb_tone_generator;

  logic clk = 1'b0;
  logic rst = 1'b0;

  tone_generator_if bus();

  tone_generator #(.W(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       audio;
    logic       active;
    logic [2:0] idx;
    int         events;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int   half_tab [8] = '{5972, 5321, 4740, 4474, 3986, 3551, 3164, 2986};

  // tick source: 0 = hold tick_level, 1 = toggle every clk, 2 = clk/32
  int   tick_mode  = 0;
  logic tick_level = 1'b0;
  int   phase      = 0;

  function automatic int half_of(int idx, int oct);
    return half_tab[idx] >> oct;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic expect_edge(logic a, logic na, logic [2:0] idx, int ev);
    exp_t e;
    e.audio  = a;
    e.active = na;
    e.idx    = idx;
    e.events = ev;
    q.push_back(e);
  endtask

  task automatic wait_queue(int n, int budget);
    int c = 0;
    while (q.size() > n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check("queue_drain", q.size(), n);
  endtask

  // Tick generator, updated on the falling edge so it is stable at posedge.
  initial begin
    bus.tick = 1'b0;
    forever begin
      @(negedge clk);
      case (tick_mode)
        0:       bus.tick = tick_level;
        1:       bus.tick = ~bus.tick;
        default: begin
          phase    = (phase + 1) % 32;
          bus.tick = (phase < 16);
        end
      endcase
    end
  end

  // Output edge monitor / scoreboard consumer.
  logic tick_prev = 1'b0;
  logic a_prev    = 1'b0;
  logic na_prev   = 1'b0;
  logic mon_ev;
  int   ev_cnt    = 0;
  exp_t mon_e;

  always begin
    @(posedge clk);
    if (!rst) begin
      tick_prev = 1'b0;
      a_prev    = 1'b0;
      na_prev   = 1'b0;
      ev_cnt    = 0;
    end else begin
      mon_ev    = bus.tick && !tick_prev;
      tick_prev = bus.tick;
      #1;
      if (mon_ev) ev_cnt++;
      if (bus.audio !== a_prev || bus.note_active !== na_prev) begin
        if (q.size() == 0) begin
          check("unexpected_edge_queue", q.size(), 1);
        end else begin
          mon_e = q.pop_front();
          check("edge_audio", bus.audio, mon_e.audio);
          check("edge_note_active", bus.note_active, mon_e.active);
          check("edge_note_idx", bus.note_idx, mon_e.idx);
          if (mon_e.events >= 0) check("edge_tick_events", ev_cnt, mon_e.events);
        end
        a_prev  = bus.audio;
        na_prev = bus.note_active;
        ev_cnt  = 0;
      end
    end
  end

  initial begin
    bus.key    = 8'h00;
    bus.octave = 2'd0;
    rst        = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_audio", bus.audio, 0);
    check("reset_note_active", bus.note_active, 0);
    check("reset_note_idx", bus.note_idx, 0);
    rst = 1'b1;
    @(negedge clk);

    // G4 octave 3, async reset in the high half, restart with key held
    tick_mode  = 1;
    bus.key    = 8'h10;
    bus.octave = 2'd3;
    expect_edge(1, 1, 4, -1);
    @(posedge clk); #1;
    check("press_latency_audio", bus.audio, 1);
    check("press_latency_active", bus.note_active, 1);
    check("press_latency_idx", bus.note_idx, 4);
    repeat (50) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_reset_audio", bus.audio, 0);
    check("async_reset_active", bus.note_active, 0);
    check("async_reset_idx", bus.note_idx, 0);
    expect_edge(1, 1, 4, -1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("restart_audio", bus.audio, 1);
    @(negedge clk);
    bus.key = 8'h00;
    expect_edge(0, 1, 4, half_of(4, 3));
    expect_edge(0, 0, 4, half_of(4, 3));
    wait_queue(0, 3000);

    // A4 octave 0, release during the low half
    bus.key    = 8'h20;
    bus.octave = 2'd0;
    expect_edge(1, 1, 5, -1);
    expect_edge(0, 1, 5, half_of(5, 0));
    wait_queue(0, 8000);
    bus.key = 8'h00;
    expect_edge(0, 0, 5, half_of(5, 0));
    wait_queue(0, 8000);

    // Priority (8'h81 -> C4) and octave shift 3, release during the high half
    bus.key    = 8'h81;
    bus.octave = 2'd3;
    expect_edge(1, 1, 0, -1);
    expect_edge(0, 1, 0, half_of(0, 3));
    expect_edge(1, 1, 0, half_of(0, 3));
    wait_queue(0, 4000);
    bus.key = 8'h00;
    expect_edge(0, 1, 0, half_of(0, 3));
    expect_edge(0, 0, 0, half_of(0, 3));
    wait_queue(0, 4000);

    // Mid-period note change C4 -> D4, octave 1
    bus.key    = 8'h01;
    bus.octave = 2'd1;
    expect_edge(1, 1, 0, -1);
    expect_edge(0, 1, 0, half_of(0, 1));
    expect_edge(1, 1, 1, half_of(0, 1));
    wait_queue(2, 10);
    repeat (500) @(negedge clk);
    bus.key = 8'h02;
    repeat (2) @(negedge clk);
    check("midperiod_idx_held", bus.note_idx, 0);
    wait_queue(0, 14000);
    bus.key = 8'h00;
    expect_edge(0, 1, 1, half_of(1, 1));
    expect_edge(0, 0, 1, half_of(1, 1));
    wait_queue(0, 12000);

    // clk/32 timebase, C5 octave 3, tick held high for 100 cycles mid-half
    tick_mode  = 2;
    bus.key    = 8'h80;
    bus.octave = 2'd3;
    expect_edge(1, 1, 7, -1);
    expect_edge(0, 1, 7, half_of(7, 3));
    wait_queue(1, 10);
    repeat (40) @(negedge clk);
    tick_level = 1'b1;
    tick_mode  = 0;
    repeat (100) @(negedge clk);
    tick_mode = 2;
    wait_queue(0, 14000);
    tick_mode = 1;
    bus.key   = 8'h00;
    expect_edge(0, 0, 7, half_of(7, 3));
    wait_queue(0, 2000);

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
